// File: rtl/instr_fetch.sv
// Program-counter register and instruction-fetch sequencer.
// Holds the architectural PC and fetches the word at that PC over a
// ready-based handshake. It presents the word to decode until the core
// retires it with advance.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc,
    input  logic [31:0] pc_next,
    input  logic        advance,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        mem_read,
    output logic [29:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        misalign,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StValid = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    // State register; reset drops any outstanding memory response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            misalign_q <= 1'b0;
            count_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    // Next-state logic: capture on mem_ready in FETCH, load PC on advance in VALID
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = misalign_q;
        count_d    = count_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (mem_ready) begin
                    instr_d = mem_rdata;
                    count_d = count_q + 32'd1;
                    state_d = StValid;
                end
            end
            StValid: begin
                if (advance) begin
                    // Low bits are dropped; a non-zero pair is only flagged
                    pc_d    = {pc_next[31:2], 2'b00};
                    instr_d = NOP_INSTR;
                    state_d = StFetch;
                    if (pc_next[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs come straight from registers or the state decode
    always_comb begin
        pc          = pc_q;
        instr       = instr_q;
        instr_valid = (state_q == StValid);
        mem_read    = (state_q == StFetch);
        mem_addr    = pc_q[31:2];
        misalign    = misalign_q;
        fetch_count = count_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by a
// randomized run, all compared against a behavioural model kept here.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] JUNK      = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        advance;
    logic [31:0] instr;
    logic        instr_valid;
    logic        mem_read;
    logic [29:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        misalign;
    logic [31:0] fetch_count;
    logic        junk_en;

    int checks = 0;
    int errors = 0;
    string phase = "reset";

    // Behavioural model: what the fetch unit currently knows
    logic [31:0] m_pc, m_instr, m_count;
    bit          m_fetching, m_valid, m_mis;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP_INSTR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .pc_next     (pc_next),
        .advance     (advance),
        .instr       (instr),
        .instr_valid (instr_valid),
        .mem_read    (mem_read),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .misalign    (misalign),
        .fetch_count (fetch_count)
    );

    // Instruction memory image: a distinct word for every address
    function automatic logic [31:0] img(input logic [29:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    assign mem_rdata = junk_en ? JUNK : img(mem_addr);

    task automatic model_reset();
        m_pc       = RESET_PC;
        m_instr    = NOP_INSTR;
        m_count    = 0;
        m_fetching = 0;
        m_valid    = 0;
        m_mis      = 0;
    endtask

    // One rising edge of the model
    task automatic model_edge();
        if (m_fetching) begin
            if (mem_ready) begin
                m_instr    = junk_en ? JUNK : img(m_pc[31:2]);
                m_count    = m_count + 1;
                m_fetching = 0;
                m_valid    = 1;
            end
        end else if (m_valid) begin
            if (advance) begin
                m_pc       = pc_next & ~32'd3;
                m_mis      = m_mis | (pc_next[1:0] != 2'b00);
                m_instr    = NOP_INSTR;
                m_valid    = 0;
                m_fetching = 1;
            end
        end else begin
            m_fetching = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s/%s: got %h, expected %h", phase, tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("instr", instr, m_valid ? m_instr : NOP_INSTR);
        chk("instr_valid", 32'(instr_valid), 32'(m_valid));
        chk("mem_read", 32'(mem_read), 32'(m_fetching));
        chk("mem_addr", 32'(mem_addr), 32'(m_pc[31:2]));
        chk("misalign", 32'(misalign), 32'(m_mis));
        chk("fetch_count", fetch_count, m_count);
    endtask

    // Advance one clock, step the model, then sample the DUT just after the edge
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic pulse_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    initial begin
        rst_n     = 1'b0;
        advance   = 1'b0;
        pc_next   = 32'd0;
        mem_ready = 1'b0;
        junk_en   = 1'b0;
        model_reset();
        #12;
        check_all();

        // Reset release with memory ready at once
        phase = "first_fetch";
        mem_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mem_read_after_release", 32'(mem_read), 32'd1);
        tick();
        chk("first_instr", instr, img(30'd0));

        // Sequential run, zero-wait memory
        phase = "sequential";
        for (int i = 0; i < 3; i++) begin
            advance = 1'b1;
            pc_next = m_pc + 32'd4;
            tick();
            advance = 1'b0;
            tick();
        end
        chk("seq_pc", pc, 32'd12);
        chk("seq_count", fetch_count, 32'd4);

        // Memory wait states with advance pulses during FETCH
        phase = "wait_states";
        advance   = 1'b1;
        pc_next   = m_pc + 32'd4;
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            advance = (i % 2 == 0);
            pc_next = 32'h0000_0800;
            tick();
        end
        advance   = 1'b0;
        mem_ready = 1'b1;
        tick();
        chk("wait_pc", pc, 32'd16);
        mem_ready = 1'b0;

        // Core stall in VALID
        phase = "stall";
        for (int i = 0; i < 4; i++) tick();
        advance = 1'b1;
        pc_next = 32'h0000_0100;
        tick();
        chk("stall_pc", pc, 32'h0000_0100);
        chk("stall_addr", 32'(mem_addr), 32'h40);
        advance   = 1'b0;
        mem_ready = 1'b1;
        tick();

        // Misaligned target, then aligned advances keep the flag
        phase = "misalign";
        advance = 1'b1;
        pc_next = 32'h0000_0206;
        tick();
        chk("mis_pc", pc, 32'h0000_0204);
        chk("mis_flag", 32'(misalign), 32'd1);
        for (int i = 0; i < 6; i++) begin
            pc_next = m_pc + 32'd4;
            tick();
        end

        // Reset during a fetch at 0x40 with a stale response
        phase = "reset_mid_fetch";
        while (!m_valid) tick();
        advance   = 1'b1;
        pc_next   = 32'h0000_0040;
        mem_ready = 1'b0;
        tick();
        advance = 1'b0;
        tick();
        chk("pre_reset_addr", 32'(mem_addr), 32'h10);
        pulse_reset();
        mem_ready = 1'b1;
        junk_en   = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("stale_count", fetch_count, 32'd0);
        chk("stale_valid", 32'(instr_valid), 32'd0);
        junk_en = 1'b0;
        tick();
        chk("post_reset_instr", instr, img(30'd0));

        // Randomized run
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            mem_ready = ($urandom_range(0, 2) != 0);
            advance   = $urandom_range(0, 1);
            junk_en   = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       pc_next = $urandom();
                1, 2:    pc_next = $urandom() & 32'h0000_FFFC;
                default: pc_next = m_pc + 32'd4;
            endcase
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
                @(negedge clk);
                rst_n = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter register and instruction-fetch sequencer, directly upstream of the PC calculation stage. It holds the architectural PC and drives it to the PC calculator as `pc_in`. It fetches the instruction at that PC from instruction memory through a ready-based handshake and presents it to decode. When the core retires the instruction (`advance`), it loads the calculator's next-PC result. All instruction-memory latency and core stalls are absorbed here.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `NOP_INSTR`, default 32'h0000_0013: value of `instr` while no fetched instruction is held (addi x0,x0,0).

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pc` output 32: current PC; feeds PC calculator `pc_in`.
- `pc_next` input 32: next PC from PC calculator, sampled only on an accepted `advance`.
- `advance` input 1: core has completed the current instruction; load `pc_next`.
- `instr` output 32: fetched instruction for decode.
- `instr_valid` output 1: `instr` holds the instruction at `pc`.
- `mem_read` output 1: instruction-memory read request.
- `mem_addr` output 30: word address, equal to `pc[31:2]`.
- `mem_rdata` input 32: read data; valid when `mem_ready` is 1.
- `mem_ready` input 1: read complete.
- `misalign` output 1: sticky flag; a `pc_next` with bits [1:0] != 0 was loaded.
- `fetch_count` output 32: number of completed fetches.

## Operation
- There are three states: IDLE, FETCH and VALID.
- **IDLE** (entered only from reset):
  - `mem_read`=0 and `instr_valid`=0.
  - Moves unconditionally to FETCH on the next edge.
- **FETCH**:
  - `mem_read`=1 and `mem_addr`=`pc[31:2]`; both are held stable until `mem_ready`.
  - On `mem_ready`=1: `instr`<=`mem_rdata`, `fetch_count`<=`fetch_count`+1 (wraps modulo 2^32), go to VALID.
  - `mem_ready` is honoured in the very first FETCH cycle.
  - `advance` is ignored in FETCH.
- **VALID**:
  - `mem_read`=0 and `instr_valid`=1; `instr` and `pc` are held.
  - On `advance`=1: `pc`<={`pc_next`[31:2],2'b00}, `instr`<=`NOP_INSTR`, go to FETCH.
  - If `pc_next`[1:0]!=0 at that `advance`, set `misalign`<=1. It stays set until reset.
- `mem_ready` outside FETCH is ignored: no capture, no count.
- `pc` changes only on an `advance` accepted in VALID, or on reset.
- A taken-branch target or a `jalr` read-data target is loaded exactly like a sequential `pc_next`.
- Reset mid-fetch:
  - All state returns to reset values immediately.
  - The outstanding memory response is dropped; `mem_ready` arriving during or after reset while in IDLE is ignored.

## Timing
- Reset values (asynchronous, while `rst_n`=0):
  - `pc`=`RESET_PC`, state=IDLE.
  - `instr`=`NOP_INSTR`, `instr_valid`=0, `mem_read`=0.
  - `misalign`=0, `fetch_count`=0.
- After `rst_n` rises: first edge gives FETCH, so `mem_read`=1 one cycle after reset release.
- Fetch latency: `instr_valid` rises on the edge after the cycle in which `mem_ready`=1.
- Best-case throughput is one instruction per 2 cycles (FETCH with immediate ready, then VALID with `advance`).
- `pc` updates on the edge ending the VALID cycle with `advance`. `mem_addr` shows the new PC in the immediately following FETCH cycle.
- All outputs are registered or decoded from state only. No combinational path exists from `mem_rdata`, `mem_ready`, `advance` or `pc_next` to any output.

## Test plan
- **Reset and first fetch:** `RESET_PC`=0, release `rst_n`, `mem_ready`=1 immediately.
  - `mem_read`=1 and `mem_addr`=0 one cycle after release.
  - Next cycle: `instr_valid`=1, `instr`=`mem_rdata`, `fetch_count`=1.
- **Sequential run:** `advance`=1 each VALID cycle, `pc_next`=`pc`+4, zero-wait memory.
  - `pc` sequence 0,4,8,12, changing every 2 cycles.
  - `fetch_count`=4 after four fetches.
- **Memory wait states:** `mem_ready` held low 5 cycles in FETCH.
  - `mem_read` and `mem_addr` stable for all 6 cycles.
  - `instr_valid`=0 throughout; `instr_valid`=1 exactly one cycle after `mem_ready`.
  - `advance` pulsed during FETCH has no effect on `pc`.
- **Core stall:** in VALID, `advance` low 4 cycles.
  - `instr`, `pc` and `instr_valid` are held and `mem_read`=0.
  - Then `advance` with `pc_next`=32'h0000_0100 gives `pc`=32'h100 and `mem_addr`=30'h40.
- **Misaligned target:** `advance` with `pc_next`=32'h0000_0206.
  - `pc`=32'h0000_0204 and `misalign`=1.
  - `misalign` remains 1 across later aligned advances until `rst_n` is pulsed.
- **Reset mid-fetch:** assert `rst_n`=0 during FETCH at `pc`=32'h40, then release with a stale `mem_ready`=1 in the IDLE cycle.
  - `pc`=`RESET_PC`, `fetch_count`=0 and `instr_valid`=0.
  - The stale data is not captured.
